// File: rtl/display_pkg.sv
// Shared definitions for the score display path: digit count, saturation
// limit, the "shows 0" blank pattern and the converter state encoding.
package display_pkg;

    localparam int          DIGITS      = 8;
    localparam logic [26:0] MAX_DISPLAY = 27'd99_999_999;
    localparam logic [7:0]  BLANK_ZERO  = 8'b1111_1110;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    // Leading-zero suppression: a digit is dark when it and every more
    // significant digit are zero; the units digit always stays lit.
    function automatic logic [DIGITS-1:0] blank_mask(input logic [4*DIGITS-1:0] bcd);
        logic seen_nz;
        blank_mask = '0;
        seen_nz    = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            seen_nz       = seen_nz | (bcd[4*i +: 4] != 4'd0);
            blank_mask[i] = ~seen_nz;
        end
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One double-dabble digit correction: add 3 to a BCD digit of 5 or more so
// the following left shift carries correctly into the next decade.
module bcd_digit_adjust (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bcd_score_converter.sv
// Iterative binary-to-BCD converter (shift-and-add-3, one bit per clock)
// producing eight held BCD digits, a leading-zero blank mask and overflow.
module bcd_score_converter #(
    parameter int WIDTH  = 27,
    parameter int DIGITS = display_pkg::DIGITS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] value,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [3:0]       BCD7,
    output logic [3:0]       BCD6,
    output logic [3:0]       BCD5,
    output logic [3:0]       BCD4,
    output logic [3:0]       BCD3,
    output logic [3:0]       BCD2,
    output logic [3:0]       BCD1,
    output logic [3:0]       BCD0,
    output logic [7:0]       blank
);

    import display_pkg::*;

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int SCR_W = 4 * DIGITS;
    localparam int MAX_W = (WIDTH > 27) ? WIDTH : 27;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shreg;
    logic [SCR_W-1:0] scratch;
    logic [SCR_W-1:0] scratch_adj;
    logic             ovf_pending;
    logic [SCR_W-1:0] bcd_q;
    logic [7:0]       blank_q;
    logic             overflow_q;
    logic             done_q;

    function automatic logic [SCR_W-1:0] saturate_bcd(input logic ovf,
                                                      input logic [SCR_W-1:0] raw);
        return ovf ? {DIGITS{4'd9}} : raw;
    endfunction

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit   (scratch[4*g +: 4]),
            .adjusted(scratch_adj[4*g +: 4])
        );
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Shift datapath; a carry out of the top decade also marks overflow.
    always_ff @(posedge clock) begin
        if (state == IDLE && start) begin
            shreg       <= value;
            scratch     <= '0;
            cnt         <= CNT_W'(WIDTH);
            ovf_pending <= MAX_W'(value) > MAX_W'(MAX_DISPLAY);
        end else if (state == SHIFT) begin
            scratch     <= {scratch_adj[SCR_W-2:0], shreg[WIDTH-1]};
            shreg       <= shreg << 1;
            cnt         <= cnt - CNT_W'(1);
            ovf_pending <= ovf_pending | scratch_adj[SCR_W-1];
        end
    end

    // Result registers: previous result held until the conversion completes.
    always_ff @(posedge clock) begin
        if (reset) begin
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            bcd_q      <= '0;
            blank_q    <= BLANK_ZERO;
        end else begin
            done_q <= (state == FINISH);
            if (state == FINISH) begin
                bcd_q      <= saturate_bcd(ovf_pending, scratch);
                blank_q    <= blank_mask(saturate_bcd(ovf_pending, scratch));
                overflow_q <= ovf_pending;
            end
        end
    end

    always @(posedge clock) begin
        if (!reset && state == SHIFT) begin
            for (int d = 0; d < DIGITS; d++) begin
                assert (scratch[4*d +: 4] <= 4'd9)
                    else $error("bcd_score_converter: scratch digit %0d exceeds 9", d);
            end
        end
    end

    assign busy     = (state != IDLE);
    assign done     = done_q;
    assign overflow = overflow_q;
    assign blank    = blank_q;
    assign BCD0     = bcd_q[3:0];
    assign BCD1     = bcd_q[7:4];
    assign BCD2     = bcd_q[11:8];
    assign BCD3     = bcd_q[15:12];
    assign BCD4     = bcd_q[19:16];
    assign BCD5     = bcd_q[23:20];
    assign BCD6     = bcd_q[27:24];
    assign BCD7     = bcd_q[31:28];

endmodule

// File: tb/tb_bcd_score_converter.sv
// Self-checking bench for bcd_score_converter: directed and random values
// compared against a decimal-arithmetic reference model.
module tb_bcd_score_converter;

    logic        clock;
    logic        reset;
    logic [26:0] value;
    logic        start;
    logic        busy, done, overflow;
    logic [3:0]  BCD7, BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0;
    logic [7:0]  blank;
    logic [31:0] bcd_all;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_bcd;
    logic [7:0]  exp_blank;
    logic        exp_ovf;

    bcd_score_converter #(.WIDTH(27), .DIGITS(8)) dut (
        .clock   (clock),
        .reset   (reset),
        .value   (value),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .overflow(overflow),
        .BCD7    (BCD7),
        .BCD6    (BCD6),
        .BCD5    (BCD5),
        .BCD4    (BCD4),
        .BCD3    (BCD3),
        .BCD2    (BCD2),
        .BCD1    (BCD1),
        .BCD0    (BCD0),
        .blank   (blank)
    );

    assign bcd_all = {BCD7, BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
            else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
            end
    endtask

    function automatic logic [31:0] model_bcd(input longint v);
        longint      x;
        logic [31:0] r;
        if (v >= 100000000) return 32'h9999_9999;
        x = v;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x           = x / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] model_blank(input longint v);
        logic [7:0] b;
        longint     p;
        if (v >= 100000000) return 8'h00;
        b = '0;
        p = 10;
        for (int i = 1; i < 8; i++) begin
            b[i] = (v < p);
            p    = p * 10;
        end
        return b;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Starts a conversion in the current cycle and returns in its done cycle.
    task automatic run_conv(input longint v, input int repulse_at);
        logic [31:0] prev_bcd;
        logic [7:0]  prev_blank;
        logic        prev_ovf;
        int          lat, hold_bad, busy_bad;
        bit          got;
        prev_bcd   = exp_bcd;
        prev_blank = exp_blank;
        prev_ovf   = exp_ovf;
        value = 27'(v);
        start = 1'b1;
        tick();
        start    = 1'b0;
        value    = 27'($urandom);
        lat      = 1;
        got      = 1'b0;
        hold_bad = 0;
        busy_bad = 0;
        while (!got && lat <= 40) begin
            if (done === 1'b1) begin
                got = 1'b1;
            end else begin
                if (busy !== 1'b1) busy_bad++;
                if ({bcd_all, blank, overflow} !== {prev_bcd, prev_blank, prev_ovf}) hold_bad++;
                if (lat == repulse_at) begin
                    start = 1'b1;
                    value = 27'd5;
                end else begin
                    start = 1'b0;
                    value = 27'($urandom);
                end
                tick();
                lat++;
            end
        end
        start     = 1'b0;
        exp_bcd   = model_bcd(v);
        exp_blank = model_blank(v);
        exp_ovf   = (v >= 100000000);
        chk("latency", got ? 64'(lat) : 64'hFFFF, 64'd29);
        chk("busy_during", 64'(busy_bad), 64'd0);
        chk("hold_prev", 64'(hold_bad), 64'd0);
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("bcd", 64'(bcd_all), 64'(exp_bcd));
        chk("blank", 64'(blank), 64'(exp_blank));
        chk("overflow", 64'(overflow), 64'(exp_ovf));
    endtask

    initial begin
        longint edge_vals[10];
        int     done_seen;
        longint v;

        reset = 1'b1;
        start = 1'b1;
        value = 27'd1234;
        exp_bcd   = '0;
        exp_blank = 8'hFE;
        exp_ovf   = 1'b0;
        repeat (3) tick();
        chk("rst_start_busy", 64'(busy), 64'd0);
        start = 1'b0;
        reset = 1'b0;
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_bcd", 64'(bcd_all), 64'd0);
        chk("rst_blank", 64'(blank), 64'hFE);
        chk("rst_ovf", 64'(overflow), 64'd0);

        run_conv(0, -1);
        tick();
        chk("done_pulse_0", 64'(done), 64'd0);

        run_conv(1234, -1);
        chk("blank_1234", 64'(blank), 64'hF0);
        tick();

        run_conv(99999999, -1);
        chk("blank_max", 64'(blank), 64'h00);
        run_conv(100000000, -1);
        chk("ovf_b2b", 64'(overflow), 64'd1);
        tick();
        chk("done_pulse_b2b", 64'(done), 64'd0);

        run_conv(42, 5);
        chk("blank_42", 64'(blank), 64'hFC);
        tick();
        chk("done_pulse_42", 64'(done), 64'd0);

        value = 27'd777;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_bcd   = '0;
        exp_blank = 8'hFE;
        exp_ovf   = 1'b0;
        chk("midrst_bcd", 64'(bcd_all), 64'd0);
        chk("midrst_blank", 64'(blank), 64'hFE);
        chk("midrst_ovf", 64'(overflow), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) done_seen++;
            tick();
        end
        chk("midrst_no_done", 64'(done_seen), 64'd0);
        run_conv(777, -1);
        tick();

        edge_vals = '{9, 10, 99, 100, 9999999, 10000000, 10000001,
                      100000001, 134217727, 5};
        foreach (edge_vals[i]) begin
            run_conv(edge_vals[i], -1);
            if (i % 2 == 0) tick();
        end

        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 2))
                0:       v = longint'($urandom_range(0, 999));
                1:       v = longint'($urandom_range(0, 99999999));
                default: v = longint'($urandom_range(0, 134217727));
            endcase
            run_conv(v, (i % 3 == 0) ? int'($urandom_range(1, 27)) : -1);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
